// File: rtl/vid_pkg.sv
// vid_pkg: shared 640x480 video timing constants, the measurement and
// coordinate types, the receiver FSM state type and saturating increments.
package vid_pkg;

  localparam int VID_H_ACTIVE = 640;
  localparam int VID_H_TOTAL  = 800;
  localparam int VID_V_ACTIVE = 480;
  localparam int VID_V_TOTAL  = 525;

  localparam int MEAS_W  = 12;
  localparam int COORD_W = 10;

  typedef logic [MEAS_W-1:0]  meas_t;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic meas_t meas_inc(meas_t v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic coord_t coord_inc(coord_t v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vtd_rx_if.sv
// vtd_rx_if: incoming sync/data-enable plus all recovered outputs of the
// timing detector. The master side sources video, the slave side receives.
interface vtd_rx_if;
  import vid_pkg::*;

  logic   hSync;
  logic   vSync;
  logic   vActive;
  coord_t hPixel;
  coord_t vLine;
  logic   deOut;
  logic   locked;
  logic   frameStart;
  logic   err;
  meas_t  hTotalMeas;
  meas_t  vTotalMeas;
  meas_t  hActMeas;
  meas_t  vActMeas;

  modport master (
    output hSync, vSync, vActive,
    input  hPixel, vLine, deOut, locked, frameStart, err,
    input  hTotalMeas, vTotalMeas, hActMeas, vActMeas
  );

  modport slave (
    input  hSync, vSync, vActive,
    output hPixel, vLine, deOut, locked, frameStart, err,
    output hTotalMeas, vTotalMeas, hActMeas, vActMeas
  );

endinterface

// File: rtl/sync_edge.sv
// sync_edge: registers one incoming sync/enable bit and flags entry into
// (lead) and exit from (trail) its asserted level POL.
module sync_edge #(
  parameter bit POL = 1'b1
) (
  input  logic clock,
  input  logic rst,
  input  logic din_i,
  output logic level_o,
  output logic lead_o,
  output logic trail_o
);

  logic s_q;
  logic p_q;

  // Input register plus one-cycle history; reset to the idle level so
  // release never produces a false edge.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      s_q <= ~POL;
      p_q <= ~POL;
    end else begin
      // NOTE: state registers use <= so every flop samples pre-edge values.
      s_q <= din_i;
      p_q <= s_q;
    end
  end

  assign level_o = (s_q == POL);
  assign lead_o  = (s_q == POL) && (p_q != POL);
  assign trail_o = (s_q != POL) && (p_q == POL);

endmodule

// File: rtl/vtd_rx.sv
// vtd_rx: video timing detector. Measures line/frame geometry from the
// incoming syncs, recovers active-area coordinates and locks once the
// timing matches the parameters for LOCK_FRAMES consecutive frames.
// Optional watchdog: define VTD_TIMEOUT_EN to drop lock when hSync stops.
module vtd_rx
  import vid_pkg::*;
#(
  parameter int H_ACTIVE    = VID_H_ACTIVE,
  parameter int H_TOTAL     = VID_H_TOTAL,
  parameter int V_ACTIVE    = VID_V_ACTIVE,
  parameter int V_TOTAL     = VID_V_TOTAL,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input logic     clock,
  input logic     rst,
  vtd_rx_if.slave bus
);

  logic hs_lvl, hs_lead, hs_trail;
  logic vs_lvl, vs_lead, vs_trail;
  logic act, va_rise, va_fall;
  logic unused_sync;

  sync_edge #(.POL(SYNC_POL)) u_hs (
    .clock, .rst, .din_i(bus.hSync),
    .level_o(hs_lvl), .lead_o(hs_lead), .trail_o(hs_trail)
  );
  sync_edge #(.POL(SYNC_POL)) u_vs (
    .clock, .rst, .din_i(bus.vSync),
    .level_o(vs_lvl), .lead_o(vs_lead), .trail_o(vs_trail)
  );
  sync_edge #(.POL(1'b1)) u_va (
    .clock, .rst, .din_i(bus.vActive),
    .level_o(act), .lead_o(va_rise), .trail_o(va_fall)
  );

  assign unused_sync = hs_lvl ^ hs_trail ^ vs_lvl ^ vs_trail;

  state_t     state_q, state_d;
  logic [3:0] match_q, match_d;
  meas_t      hcnt_q, hcnt_d, hact_cnt_q, hact_cnt_d;
  meas_t      vcnt_q, vcnt_d, vact_cnt_q, vact_cnt_d;
  meas_t      htot_q, htot_d, hact_q, hact_d;
  meas_t      vtot_q, vtot_d, vact_q, vact_d;
  logic       line_act_q, line_act_d;
  coord_t     hpix_q, hpix_d, vline_q, vline_d;
  logic       de_q, fs_q, err_q, err_d;
  logic       timeout, frame_ok, line_bad;

`ifdef VTD_TIMEOUT_EN
  assign timeout = !hs_lead && (hcnt_q == meas_t'(2 * H_TOTAL - 1));
`else
  assign timeout = 1'b0;
`endif

  // Line and frame measurement counters with capture on sync leading edges.
  always_comb begin
    // NOTE: defaults first give every path an assignment, so no latch forms.
    hcnt_d     = hs_lead ? '0 : meas_inc(hcnt_q);
    hact_cnt_d = act ? meas_inc(hact_cnt_q) : hact_cnt_q;
    vcnt_d     = vcnt_q;
    vact_cnt_d = vact_cnt_q;
    line_act_d = line_act_q | act;
    htot_d     = htot_q;
    hact_d     = hact_q;
    vtot_d     = vtot_q;
    vact_d     = vact_q;
    if (hs_lead) begin
      htot_d     = meas_inc(hcnt_q);
      hact_cnt_d = act ? meas_t'(1) : '0;
      if (hact_cnt_q != '0) hact_d = hact_cnt_q;
      vcnt_d     = meas_inc(vcnt_q);
      if (line_act_q) vact_cnt_d = meas_inc(vact_cnt_q);
      line_act_d = act;
    end
    if (timeout) htot_d = '1;
    // A coincident line edge has already been counted into the ending frame.
    if (vs_lead) begin
      vtot_d     = vcnt_d;
      vact_d     = vact_cnt_d;
      vcnt_d     = '0;
      vact_cnt_d = '0;
    end
  end

  // Active-area coordinates, aligned with the registered data enable.
  always_comb begin
    hpix_d  = hpix_q;
    vline_d = vline_q;
    if (va_rise)  hpix_d = '0;
    else if (act) hpix_d = coord_inc(hpix_q);
    if (vs_lead)      vline_d = '0;
    else if (va_fall) vline_d = coord_inc(vline_q);
  end

  assign frame_ok = (htot_d == meas_t'(H_TOTAL))  && (hact_d == meas_t'(H_ACTIVE)) &&
                    (vtot_d == meas_t'(V_TOTAL))  && (vact_d == meas_t'(V_ACTIVE));
  assign line_bad = hs_lead && (htot_d != meas_t'(H_TOTAL));

  // Lock FSM: the frame ending at the SEARCH exit edge is never compared.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    err_d   = 1'b0;
    unique case (state_q)
      SEARCH: if (vs_lead) begin
        state_d = CHECK;
        match_d = '0;
      end
      CHECK: if (vs_lead) begin
        if (frame_ok) begin
          match_d = match_q + 4'd1;
          if (match_d == 4'(LOCK_FRAMES)) state_d = LOCKED;
        end else begin
          state_d = SEARCH;
          match_d = '0;
        end
      end
      LOCKED: if (line_bad || (vs_lead && !frame_ok)) begin
        state_d = SEARCH;
        match_d = '0;
        err_d   = 1'b1;
      end
      default: state_d = SEARCH;
    endcase
    if (timeout) begin
      state_d = SEARCH;
      match_d = '0;
      err_d   = 1'b1;
    end
  end

  // All state and output registers; reset clears everything asynchronously.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q    <= SEARCH;
      match_q    <= '0;
      hcnt_q     <= '0;
      hact_cnt_q <= '0;
      vcnt_q     <= '0;
      vact_cnt_q <= '0;
      line_act_q <= 1'b0;
      htot_q     <= '0;
      hact_q     <= '0;
      vtot_q     <= '0;
      vact_q     <= '0;
      hpix_q     <= '0;
      vline_q    <= '0;
      de_q       <= 1'b0;
      fs_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      match_q    <= match_d;
      hcnt_q     <= hcnt_d;
      hact_cnt_q <= hact_cnt_d;
      vcnt_q     <= vcnt_d;
      vact_cnt_q <= vact_cnt_d;
      line_act_q <= line_act_d;
      htot_q     <= htot_d;
      hact_q     <= hact_d;
      vtot_q     <= vtot_d;
      vact_q     <= vact_d;
      hpix_q     <= hpix_d;
      vline_q    <= vline_d;
      de_q       <= act;
      fs_q       <= vs_lead;
      err_q      <= err_d;
    end
  end

  assign bus.hPixel     = hpix_q;
  assign bus.vLine      = vline_q;
  assign bus.deOut      = de_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.frameStart = fs_q;
  assign bus.err        = err_q;
  assign bus.hTotalMeas = htot_q;
  assign bus.vTotalMeas = vtot_q;
  assign bus.hActMeas   = hact_q;
  assign bus.vActMeas   = vact_q;

endmodule

// File: tb/tb_vtd_rx.sv
// tb_vtd_rx: self-checking bench for vtd_rx. Uses a reduced raster
// (44x118 clocks, 40x114 active) so several frames fit in a short run while
// still reaching pixel (37,112). Honours VTD_TIMEOUT_EN for the watchdog case.
`timescale 1ns/1ps
module tb_vtd_rx;
  import vid_pkg::*;

  localparam int HT = 44, HA = 40, HS_W = 2, H_START = 3;
  localparam int VT = 118, VA = 114, VS_W = 2, V_START = 3;
  localparam int LOCKN = 2;

  logic clock = 1'b0;
  logic rst;
  vtd_rx_if bus();

  vtd_rx #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
    .SYNC_POL(1'b0), .LOCK_FRAMES(LOCKN)
  ) dut (
    .clock(clock),
    .rst(rst),
    .bus(bus)
  );

  always #5 clock = ~clock;

  typedef struct { int line; int col; int hpix; int vline; bit de; } vec_t;
  typedef struct { int due; int hpix; int vline; bit de; } sb_t;

  vec_t vecs[7];
  sb_t  sb_q[$];
  sb_t  cur;
  bit   sb_en = 1'b0;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int fs_cnt = 0, err_rises = 0, err_cycles = 0;
  int lock_fs = -1, err_fs = -1, rst_fs = 0, base_err = 0;
  bit err_prev = 1'b0, locked_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Event tracking and scoreboard drain, sampled on the falling edge.
  always @(negedge clock) begin
    if (bus.frameStart === 1'b1) fs_cnt++;
    if (bus.err === 1'b1) begin
      err_cycles++;
      if (!err_prev) begin
        err_rises++;
        err_fs = fs_cnt;
      end
    end
    if (bus.locked === 1'b1 && !locked_prev) lock_fs = fs_cnt;
    err_prev    = (bus.err === 1'b1);
    locked_prev = (bus.locked === 1'b1);
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      cur = sb_q.pop_front();
      check("sb_hPixel", bus.hPixel, cur.hpix);
      check("sb_vLine", bus.vLine, cur.vline);
      check("sb_deOut", bus.deOut, cur.de);
    end
  end

  task automatic drive(input logic hs, input logic vs, input logic va);
    @(posedge clock);
    #1;
    bus.hSync   = hs;
    bus.vSync   = vs;
    bus.vActive = va;
  endtask

  // One full frame of active-low syncs; vSync leads together with hSync.
  task automatic drive_frame(input int long_line);
    int   len;
    logic va;
    sb_t  e;
    for (int l = 0; l < VT; l++) begin
      len = (l == long_line) ? HT + 1 : HT;
      for (int c = 0; c < len; c++) begin
        va = (l >= V_START) && (l < V_START + VA) && (c >= H_START) && (c < H_START + HA);
        drive(!(c < HS_W), !(l < VS_W), va);
        if (sb_en) begin
          for (int k = 0; k < 7; k++) begin
            if (vecs[k].line == l && vecs[k].col == c) begin
              e.due   = cyc + 2;
              e.hpix  = vecs[k].hpix;
              e.vline = vecs[k].vline;
              e.de    = vecs[k].de;
              sb_q.push_back(e);
            end
          end
        end
      end
    end
  endtask

  task automatic check_meas(input string tag);
    check({tag, "_hTotalMeas"}, bus.hTotalMeas, HT);
    check({tag, "_vTotalMeas"}, bus.vTotalMeas, VT);
    check({tag, "_hActMeas"}, bus.hActMeas, HA);
    check({tag, "_vActMeas"}, bus.vActMeas, VA);
  endtask

  initial begin
    // {raster line, raster column} -> {hPixel, vLine, deOut} two clocks later
    vecs[0] = '{3,   3,  0,   0,   1'b1};  // first active pixel
    vecs[1] = '{115, 40, 37,  112, 1'b1};  // active (37,112)
    vecs[2] = '{116, 42, 39,  113, 1'b1};  // last active pixel
    vecs[3] = '{50,  2,  39,  47,  1'b0};  // blanking holds coordinates
    vecs[4] = '{1,   20, 39,  0,   1'b0};  // vLine cleared by vSync
    vecs[5] = '{60,  43, 39,  58,  1'b0};  // vLine steps on the falling edge
    vecs[6] = '{117, 10, 39,  114, 1'b0};  // after the last active line

    rst = 1'b0;
    bus.hSync = 1'b1;
    bus.vSync = 1'b1;
    bus.vActive = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    check("rst_hPixel", bus.hPixel, 0);
    check("rst_vLine", bus.vLine, 0);
    check("rst_deOut", bus.deOut, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_frameStart", bus.frameStart, 0);
    check("rst_err", bus.err, 0);
    check("rst_hTotalMeas", bus.hTotalMeas, 0);
    check("rst_vTotalMeas", bus.vTotalMeas, 0);
    check("rst_hActMeas", bus.hActMeas, 0);
    check("rst_vActMeas", bus.vActMeas, 0);
    @(posedge clock);
    #1;
    rst = 1'b1;

    // Acquisition: lock at the 3rd vSync edge.
    for (int f = 0; f < 4; f++) drive_frame(-1);
    check("acq_lock_edge", lock_fs, 3);
    check("acq_locked", bus.locked, 1);
    check("acq_err", err_rises, 0);
    check("acq_frameStart", fs_cnt, 4);
    check_meas("acq");

    // Locked stream with coordinate vectors; syncs lead in the same cycle.
    sb_en = 1'b1;
    drive_frame(-1);
    sb_en = 1'b0;
    check("vec_drained", sb_q.size(), 0);
    check("same_edge_locked", bus.locked, 1);
    check("same_edge_err", err_rises, 0);
    check("same_edge_frameStart", fs_cnt, 5);
    check("same_edge_vTotalMeas", bus.vTotalMeas, VT);

    // One line lengthened by a clock, then relock.
    drive_frame(60);
    check("long_err_pulses", err_rises, 1);
    check("long_err_width", err_cycles, 1);
    check("long_err_frame", err_fs, 6);
    check("long_unlocked", bus.locked, 0);
    drive_frame(-1);
    drive_frame(-1);
    check("long_not_yet", bus.locked, 0);
    drive_frame(-1);
    check("long_relocked", bus.locked, 1);
    check("long_relock_edge", lock_fs, err_fs + 3);
    check("long_err_once", err_rises, 1);

    // Reset pulse mid-line while locked.
    fork
      drive_frame(-1);
      begin
        repeat (20 * HT + 13) @(posedge clock);
        #3;
        rst = 1'b0;
        #1;
        check("arst_locked", bus.locked, 0);
        check("arst_hPixel", bus.hPixel, 0);
        check("arst_deOut", bus.deOut, 0);
        check("arst_hTotalMeas", bus.hTotalMeas, 0);
        check("arst_vActMeas", bus.vActMeas, 0);
        @(posedge clock);
        #3;
        rst = 1'b1;
        rst_fs = fs_cnt;
      end
    join
    drive_frame(-1);
    drive_frame(-1);
    check("arst_partial_ignored", bus.locked, 0);
    drive_frame(-1);
    check("arst_relocked", bus.locked, 1);
    check("arst_relock_edge", lock_fs, rst_fs + 3);

    // hSync stops for longer than two lines.
    base_err = err_rises;
    repeat (2 * HT + 10) drive(1'b1, 1'b1, 1'b0);
`ifdef VTD_TIMEOUT_EN
    check("wd_err", err_rises - base_err, 1);
    check("wd_hTotalMeas", bus.hTotalMeas, 4095);
    check("wd_locked", bus.locked, 0);
`else
    check("wd_err", err_rises - base_err, 0);
    check("wd_hTotalMeas", bus.hTotalMeas, HT);
    check("wd_locked", bus.locked, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
